// File: rtl/nexys_starship_pkg.sv
// nexys_starship_pkg: state encoding, LFSR mask, spawn thresholds and side indices
// shared by the spawn scheduler and its LFSR.
package nexys_starship_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        OVER = 3'b100
    } state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam logic [4:0] THRESH_L0 = 5'd4;
    localparam logic [4:0] THRESH_L1 = 5'd6;
    localparam logic [4:0] THRESH_L2 = 5'd8;
    localparam logic [4:0] THRESH_L3 = 5'd10;

    localparam int SIDE_TOP   = 0;
    localparam int SIDE_BTM   = 1;
    localparam int SIDE_LEFT  = 2;
    localparam int SIDE_RIGHT = 3;

    // Spawn threshold out of 16 for a given difficulty level
    function automatic logic [4:0] threshold(input logic [1:0] lvl);
        return lvl == 2'd0 ? THRESH_L0 :
               lvl == 2'd1 ? THRESH_L1 :
               lvl == 2'd2 ? THRESH_L2 : THRESH_L3;
    endfunction

endpackage

// File: rtl/spawn_scheduler_lfsr16.sv
// lfsr16: 16-bit Galois right-shift LFSR that advances every tick and
// reloads its seed if it ever reaches the all-zero lock-up state.
module lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        timer_clk,
    input  logic        Reset,
    output logic [15:0] value
);

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset)
            value <= SEED;
        else
            value <= value == 16'h0 ? SEED : (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0);
    end

endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: turns an LFSR into per-side spawn pulses whose probability
// ramps with play time, with a per-side cooldown; also tracks game time and level.
module spawn_scheduler
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          LEVEL_PERIOD = 20,
    parameter logic [1:0]  MAX_LEVEL    = 2'd3,
    parameter int          COOLDOWN     = 2
) (
    input  logic       timer_clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    output logic       top_random,
    output logic       btm_random,
    output logic       left_random,
    output logic       right_random,
    output logic [1:0] level,
    output logic [7:0] game_time,
    output logic       q_Idle,
    output logic       q_Run,
    output logic       q_Over
);

    localparam int LCW = $clog2(LEVEL_PERIOD + 1);
    localparam int CW  = $clog2(COOLDOWN + 2);

    state_t           state;
    logic [15:0]      lfsr;
    logic [LCW-1:0]   level_cnt;
    logic [3:0]       req;
    logic             run_step;
    logic             start;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .timer_clk(timer_clk),
        .Reset(Reset),
        .value(lfsr)
    );

    // A game-over edge in RUN wins over every RUN update
    assign run_step = state == RUN && !gameover_ctrl;
    assign start    = state == IDLE && play_flag && !gameover_ctrl;

    for (genvar s = 0; s < 4; s++) begin : g_side
        logic [CW-1:0] cd;
        logic          hit;
        logic          fire;
        assign hit    = cd == '0 && {1'b0, lfsr[4*s +: 4]} < threshold(level);
        assign req[s] = fire;
        always_ff @(posedge timer_clk or posedge Reset) begin
            if (Reset) begin
                cd   <= '0;
                fire <= 1'b0;
            end else begin
                fire <= run_step && hit;
                if (start)
                    cd <= '0;
                else if (run_step)
                    cd <= hit ? CW'(COOLDOWN) : cd - CW'(cd != '0);
            end
        end
    end

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            level     <= 2'd0;
            game_time <= 8'd0;
            level_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= RUN;
                    level     <= 2'd0;
                    game_time <= 8'd0;
                    level_cnt <= '0;
                end
                RUN: if (gameover_ctrl) begin
                    state <= OVER;
                end else begin
                    game_time <= game_time + 8'(game_time != 8'hFF);
                    if (level_cnt == LCW'(LEVEL_PERIOD - 1)) begin
                        level_cnt <= '0;
                        level     <= level < MAX_LEVEL ? level + 2'd1 : level;
                    end else begin
                        level_cnt <= level_cnt + LCW'(1);
                    end
                end
                OVER: if (!play_flag) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign top_random   = req[SIDE_TOP];
    assign btm_random   = req[SIDE_BTM];
    assign left_random  = req[SIDE_LEFT];
    assign right_random = req[SIDE_RIGHT];
    assign q_Idle       = state == IDLE;
    assign q_Run        = state == RUN;
    assign q_Over       = state == OVER;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: directed and random play sessions; a reference model queues
// the expected outputs at each edge and a negedge monitor pops and compares them.
module tb_spawn_scheduler;

    logic       timer_clk = 1'b0;
    logic       Reset = 1'b0;
    logic       play_flag = 1'b0;
    logic       gameover_ctrl = 1'b0;
    logic       top_random, btm_random, left_random, right_random;
    logic [1:0] level;
    logic [7:0] game_time;
    logic       q_Idle, q_Run, q_Over;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] rq;
        int         lvl;
        int         gt;
        int         st;
    } exp_t;

    exp_t sb[$];

    spawn_scheduler dut (
        .timer_clk(timer_clk),
        .Reset(Reset),
        .play_flag(play_flag),
        .gameover_ctrl(gameover_ctrl),
        .top_random(top_random),
        .btm_random(btm_random),
        .left_random(left_random),
        .right_random(right_random),
        .level(level),
        .game_time(game_time),
        .q_Idle(q_Idle),
        .q_Run(q_Run),
        .q_Over(q_Over)
    );

    always #5 timer_clk = ~timer_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: states 0=idle 1=run 2=over, counters as plain integers
    int          m_st, m_lvl, m_gt, m_lc;
    int          m_cd[4];
    logic [15:0] m_lf, m_cur;
    logic [3:0]  m_rq;

    always @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            m_st = 0; m_lvl = 0; m_gt = 0; m_lc = 0; m_rq = 4'd0;
            m_lf = 16'hACE1;
            m_cd = '{0, 0, 0, 0};
            sb.delete();
        end else begin
            m_cur = m_lf;
            m_lf  = m_cur == 16'h0 ? 16'hACE1 : m_cur[0] ? (m_cur >> 1) ^ 16'hB400 : m_cur >> 1;
            m_rq  = 4'd0;
            if (m_st == 0) begin
                if (play_flag && !gameover_ctrl) begin
                    m_st = 1; m_gt = 0; m_lvl = 0; m_lc = 0;
                    m_cd = '{0, 0, 0, 0};
                end
            end else if (m_st == 1) begin
                if (gameover_ctrl) m_st = 2;
                else begin
                    for (int s = 0; s < 4; s++) begin
                        if (m_cd[s] == 0 && int'((m_cur >> (4 * s)) & 16'hF) < 4 + 2 * m_lvl) begin
                            m_rq[s]  = 1'b1;
                            m_cd[s]  = 2;
                        end else if (m_cd[s] > 0) m_cd[s]--;
                    end
                    if (m_gt < 255) m_gt++;
                    m_lc++;
                    if (m_lc == 20) begin
                        m_lc = 0;
                        if (m_lvl < 3) m_lvl++;
                    end
                end
            end else if (!play_flag) m_st = 0;
            sb.push_back('{m_rq, m_lvl, m_gt, m_st});
        end
    end

    int   cyc = 0;
    int   last[4] = '{-100, -100, -100, -100};
    exp_t e_mon;
    logic [3:0] got_rq;

    always @(negedge timer_clk) begin
        cyc++;
        got_rq = {right_random, left_random, btm_random, top_random};
        if (Reset) last = '{-100, -100, -100, -100};
        else if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("requests", int'(got_rq), int'(e_mon.rq));
            chk("level", int'(level), e_mon.lvl);
            chk("game_time", int'(game_time), e_mon.gt);
            chk("state", int'({q_Over, q_Run, q_Idle}), 1 << e_mon.st);
            for (int k = 0; k < 4; k++)
                if (got_rq[k]) begin
                    chk("cooldown_gap", int'((cyc - last[k]) >= 3), 1);
                    last[k] = cyc;
                end
        end
    end

    task automatic tick();
        @(negedge timer_clk);
        #1;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #1;
        chk("async_rst_idle", int'(q_Idle), 1);
        chk("async_rst_req", int'({right_random, left_random, btm_random, top_random}), 0);
        chk("async_rst_gt", int'(game_time), 0);
        chk("async_rst_lvl", int'(level), 0);
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        #1 Reset = 1'b1;
        repeat (2) @(negedge timer_clk);
        #1 Reset = 1'b0;
        tick();
        chk("idle_after_reset", int'(q_Idle), 1);
        chk("idle_req", int'({right_random, left_random, btm_random, top_random}), 0);
        chk("idle_gt", int'(game_time), 0);
        play_flag = 1'b1;
        for (int i = 1; i <= 66; i++) begin
            tick();
            if (i == 20) chk("level_before_20", int'(level), 0);
            if (i == 21) chk("level_at_20", int'(level), 1);
            if (i == 41) chk("level_at_40", int'(level), 2);
            if (i == 61) chk("level_at_60", int'(level), 3);
        end
        chk("run_65", int'(q_Run), 1);
        chk("gt_65", int'(game_time), 65);
        chk("level_65", int'(level), 3);
        gameover_ctrl = 1'b1;
        tick();
        chk("over_1", int'(q_Over), 1);
        gameover_ctrl = 1'b0;
        play_flag = 1'b0;
        tick();
        chk("idle_1", int'(q_Idle), 1);
        play_flag = 1'b1;
        repeat (31) tick();
        gameover_ctrl = 1'b1;
        tick();
        chk("over_30", int'(q_Over), 1);
        chk("over_30_gt", int'(game_time), 30);
        chk("over_30_lvl", int'(level), 1);
        chk("over_30_req", int'({right_random, left_random, btm_random, top_random}), 0);
        gameover_ctrl = 1'b0;
        tick();
        chk("over_frozen_gt", int'(game_time), 30);
        play_flag = 1'b0;
        tick();
        chk("idle_2", int'(q_Idle), 1);
        play_flag = 1'b1;
        gameover_ctrl = 1'b1;
        tick();
        chk("idle_blocked", int'(q_Idle), 1);
        gameover_ctrl = 1'b0;
        tick();
        chk("run_restart", int'(q_Run), 1);
        chk("run_restart_gt", int'(game_time), 0);
        repeat (10) tick();
        play_flag = 1'b0;
        pulse_reset();
        tick();
        chk("idle_after_rst2", int'(q_Idle), 1);
        play_flag = 1'b1;
        repeat (270) tick();
        chk("gt_saturate", int'(game_time), 255);
        chk("level_saturate", int'(level), 3);
        repeat (3000) begin
            play_flag     = $urandom_range(0, 99) < 92;
            gameover_ctrl = $urandom_range(0, 99) < 2;
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else tick();
        end
        play_flag = 1'b0;
        gameover_ctrl = 1'b0;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
Upstream stage of the four per-side monster state machines (top/bottom/left/right). Runs on timer_clk and produces the per-side random spawn-request bits (top_random etc.) from a 16-bit LFSR. Spawn probability ramps with a difficulty level derived from elapsed play time, and a per-side cooldown prevents back-to-back spawns. It also exports elapsed game time and current level to the display and score logic.

Parameters:
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
LEVEL_PERIOD, 20, timer_clk ticks in RUN per level step.
MAX_LEVEL, 3, level saturation value (level is 2 bits).
COOLDOWN, 2, ticks a side's request is forced low after it asserts.

Ports:
timer_clk  input  1  game tick clock
Reset  input  1  asynchronous, active-high
play_flag  input  1  start/continue game, level-sensitive
gameover_ctrl  input  1  any side reported game over
top_random  output  1  spawn request, top side
btm_random  output  1  spawn request, bottom side
left_random  output  1  spawn request, left side
right_random  output  1  spawn request, right side
level  output  2  current difficulty, 0..MAX_LEVEL
game_time  output  8  ticks spent in RUN, saturating
q_Idle, q_Run, q_Over  output  1 each  one-hot state

Behaviour:
- Reset (async): state=IDLE, lfsr=LFSR_SEED, all *_random=0, level=0, game_time=0, level_cnt=0, all cooldown counters=0.
- All registers update on posedge timer_clk. Outputs are registered, 1-tick latency from the LFSR value. Each level is held a full timer_clk period, so Clk-domain consumers sample it at least once.
- LFSR: Galois right-shift, mask 16'hB400. next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). Advances every tick in every state. If lfsr==0 (illegal), it loads LFSR_SEED.
- Slices: top=lfsr[3:0], btm=lfsr[7:4], left=lfsr[11:8], right=lfsr[15:12], taken from the current (pre-advance) value.
- Threshold by level: 0->4, 1->6, 2->8, 3->10 (of 16).
- States:
  - IDLE: all *_random=0. Go to RUN when play_flag && !gameover_ctrl. On that transition: game_time=0, level=0, level_cnt=0, cooldowns=0.
  - RUN: for each side, *_random = (cooldown==0) && (slice < threshold[level]). When a side asserts, its cooldown loads COOLDOWN. Otherwise a nonzero cooldown decrements. game_time increments and saturates at 255. level_cnt increments; when level_cnt==LEVEL_PERIOD-1 it clears and level increments, saturating at MAX_LEVEL. gameover_ctrl=1 -> OVER. This takes priority over every RUN update: that edge drives all *_random=0 and leaves game_time/level unchanged.
  - OVER: all *_random=0. game_time and level are frozen for the score display. Go to IDLE when play_flag==0.
  - Illegal state encoding -> IDLE.
- Each request is a 1-tick pulse. With COOLDOWN=2 a side asserts at most once every 3 ticks.
- Reset mid-RUN: immediate return to reset values, with no partial pulse held.

Decomposition:
- Shared package nexys_starship_pkg: state one-hot constants (IDLE=3'b001, RUN=3'b010, OVER=3'b100), LFSR mask 16'hB400, threshold table constants, and side-index constants.
- One sub-module: lfsr16 (seed parameter, zero-lock guard, outputs the current value).
- Four cooldown/compare slices are generated inline.

Test Plan:
- Reset, then 1 tick with play_flag=0 -> lfsr=16'hE270. All *_random=0, q_Idle=1, game_time=0.
- Raise play_flag, hold for 65 ticks -> q_Run=1. level steps 0->1->2->3 after RUN ticks 20, 40 and 60, then stays at 3. game_time=65.
- In RUN, compare each tick against a reference model of LFSR/threshold/cooldown -> exact match on all four requests. After any assertion, that side is 0 for the next 2 ticks.
- Assert gameover_ctrl at RUN tick 30 -> next edge q_Over=1, all requests 0, game_time frozen at 30, level=1. Drop play_flag -> q_Idle=1 next tick.
- In IDLE, assert play_flag and gameover_ctrl together -> stays IDLE. Deassert gameover_ctrl -> RUN next tick with game_time=0.
- Assert Reset asynchronously mid-RUN (between edges) -> outputs return to reset values immediately. After release, behaviour matches the first scenario.
